// File: rtl/conv_line_stream_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : conv_pkg
//  Description : Shared definitions for the conv_line_stream block: FSM
//                state encoding, sizing helpers (clog2, tap count,
//                accumulator width) and the output shift-and-saturate
//                function.
//  Revision    : 1.0 - initial release
// ============================================================================
package conv_pkg;

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_MAC  = 2'd1,
        ST_OUT  = 2'd2
    } state_e;

    // Working width of the saturation helper; accumulators are sign-extended
    // into it so one function serves every parameterisation.
    localparam int SAT_W = 128;

    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = 1;
        while (v < n) begin
            v = v * 2;
            r = r + 1;
        end
        return r;
    endfunction

    // Counter/index width that never collapses to zero bits.
    function automatic int idx_width(input int n);
        return (clog2(n) < 1) ? 1 : clog2(n);
    endfunction

    function automatic int taps(input int d, input int f);
        return d * f * f;
    endfunction

    // Full-precision product plus enough headroom for every tap.
    function automatic int acc_width(input int dw, input int d, input int f);
        return 2 * dw + clog2(taps(d, f));
    endfunction

    // Arithmetic shift right by frac, then clamp to a signed dw-bit range.
    function automatic logic signed [SAT_W-1:0] saturate(
        input logic signed [SAT_W-1:0] acc,
        input int                      frac,
        input int                      dw
    );
        logic signed [SAT_W-1:0] sh;
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        sh = acc >>> frac;
        hi = (SAT_W'(1) << (dw - 1)) - SAT_W'(1);
        lo = ~hi;
        if (sh > hi) begin
            return hi;
        end
        if (sh < lo) begin
            return lo;
        end
        return sh;
    endfunction

endpackage
`default_nettype wire

// File: rtl/conv_line_stream_if.sv
`default_nettype none
// ============================================================================
//  Module      : conv_line_stream_if
//  Description : Row-stream bus of the convolution stage: input row
//                handshake, filter load strobe/data and output row
//                handshake with frame marker.
//  Ports       : in_valid/in_ready/row_in, filter_load/filter_in,
//                out_valid/out_ready/row_out/out_last
//  Modports    : master - image source / sink side, slave - conv stage
//  Revision    : 1.0 - initial release
// ============================================================================
interface conv_line_stream_if #(
    parameter int DATA_WIDTH = 16,
    parameter int D          = 1,
    parameter int W          = 64,
    parameter int F          = 3
) ();
    localparam int ROW_W  = D * W * DATA_WIDTH;
    localparam int FILT_W = D * F * F * DATA_WIDTH;
    localparam int OUT_W  = (W - F + 1) * DATA_WIDTH;

    logic              in_valid;
    logic              in_ready;
    logic [ROW_W-1:0]  row_in;
    logic              filter_load;
    logic [FILT_W-1:0] filter_in;
    logic              out_valid;
    logic              out_ready;
    logic [OUT_W-1:0]  row_out;
    logic              out_last;

    modport master (
        output in_valid, row_in, filter_load, filter_in, out_ready,
        input  in_ready, out_valid, row_out, out_last
    );

    modport slave (
        input  in_valid, row_in, filter_load, filter_in, out_ready,
        output in_ready, out_valid, row_out, out_last
    );
endinterface
`default_nettype wire

// File: rtl/conv_line_stream_line_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : conv_line_buffer
//  Description : F-row line buffer. Row 0 is the oldest; a shift moves every
//                row up by one and writes the new row into row F-1. The tap
//                read port returns, for a given (ky, ch, kx), the W-F+1
//                pixels at columns kx .. kx+W-F of that row/channel.
//  Ports       : clk, reset      - clock, synchronous active-high reset
//                shift_i, row_i  - shift strobe and incoming row
//                ky_i/ch_i/kx_i  - tap coordinates
//                taps_o          - one pixel per output column
//  Revision    : 1.0 - initial release
// ============================================================================
module conv_line_buffer
    import conv_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int D          = 1,
    parameter int W          = 64,
    parameter int F          = 3
) (
    input  wire logic                               clk,
    input  wire logic                               reset,
    input  wire logic                               shift_i,
    input  wire logic [D*W*DATA_WIDTH-1:0]          row_i,
    input  wire logic [idx_width(F)-1:0]            ky_i,
    input  wire logic [idx_width(D)-1:0]            ch_i,
    input  wire logic [idx_width(F)-1:0]            kx_i,
    output logic      [(W-F+1)*DATA_WIDTH-1:0]      taps_o
);
    localparam int ROW_W = D * W * DATA_WIDTH;
    localparam int NC    = W - F + 1;

    logic [ROW_W-1:0] buf_q [F];
    logic [ROW_W-1:0] w_row;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < F; i++) begin
                buf_q[i] <= '0;
            end
        end else if (shift_i) begin
            for (int i = 0; i < F - 1; i++) begin
                buf_q[i] <= buf_q[i + 1];
            end
            buf_q[F-1] <= row_i;
        end
    end

    always_comb begin
        w_row  = buf_q[ky_i];
        taps_o = '0;
        for (int c = 0; c < NC; c++) begin
            taps_o[c*DATA_WIDTH +: DATA_WIDTH] =
                w_row[(int'(ch_i) * W + c + int'(kx_i)) * DATA_WIDTH +: DATA_WIDTH];
        end
    end
endmodule
`default_nettype wire

// File: rtl/conv_line_stream.sv
`default_nettype none
// ============================================================================
//  Module      : conv_line_stream
//  Description : Streaming 2-D convolution stage. Accepts one D-channel row
//                per handshake into an F-row line buffer; once F rows of the
//                current frame are buffered, every accepted row triggers a
//                D*F*F-cycle MAC pass (all W-F+1 columns in parallel, one tap
//                per cycle) and one saturated output row.
//  Ports       : clk, reset - clock, synchronous active-high reset
//                bus        - conv_line_stream_if.slave (row in, filter load,
//                             row out with out_last frame marker)
//  Config      : CONV_LINE_STREAM_RELU_EN - when defined, negative outputs
//                are forced to zero after saturation.
//  Revision    : 1.0 - initial release
// ============================================================================
module conv_line_stream
    import conv_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int FRAC_BITS  = 8,
    parameter int D          = 1,
    parameter int H          = 64,
    parameter int W          = 64,
    parameter int F          = 3
) (
    input  wire logic          clk,
    input  wire logic          reset,
    conv_line_stream_if.slave  bus
);
    localparam int TAPS      = taps(D, F);
    localparam int ACC_WIDTH = acc_width(DATA_WIDTH, D, F);
    localparam int NC        = W - F + 1;
    localparam int TW        = idx_width(TAPS);
    localparam int KW        = idx_width(F);
    localparam int CW        = idx_width(D);
    localparam int RW        = idx_width(H + 1);

    if (F > H || F > W) begin : g_bad_geometry
        $error("conv_line_stream: filter size F must not exceed H or W");
    end

    state_e                          state_q;
    logic [RW-1:0]                   row_cnt_q;
    logic [D*F*F*DATA_WIDTH-1:0]     filt_q;
    logic [TW-1:0]                   t_q;
    logic [KW-1:0]                   kx_q;
    logic [KW-1:0]                   ky_q;
    logic [CW-1:0]                   ch_q;
    logic signed [ACC_WIDTH-1:0]     acc_q [NC];
    logic [NC*DATA_WIDTH-1:0]        row_out_q;
    logic                            out_valid_q;
    logic                            out_last_q;

    logic [NC*DATA_WIDTH-1:0]        w_taps;
    logic signed [DATA_WIDTH-1:0]    w_filt;
    logic signed [2*DATA_WIDTH-1:0]  w_prod [NC];
    logic signed [ACC_WIDTH-1:0]     acc_d  [NC];
    logic signed [SAT_W-1:0]         w_sat  [NC];
    logic [NC*DATA_WIDTH-1:0]        row_out_d;
    logic                            w_accept;

    assign w_accept      = bus.in_valid && (state_q == ST_LOAD);
    assign bus.in_ready  = (state_q == ST_LOAD);
    assign bus.out_valid = out_valid_q;
    assign bus.out_last  = out_last_q;
    assign bus.row_out   = row_out_q;

    conv_line_buffer #(
        .DATA_WIDTH (DATA_WIDTH),
        .D          (D),
        .W          (W),
        .F          (F)
    ) u_line_buffer (
        .clk     (clk),
        .reset   (reset),
        .shift_i (w_accept),
        .row_i   (bus.row_in),
        .ky_i    (ky_q),
        .ch_i    (ch_q),
        .kx_i    (kx_q),
        .taps_o  (w_taps)
    );

    // Column MAC array; row_out_d is the final-tap result, captured into the
    // output register on the last MAC cycle so OUT presents registered data.
    always_comb begin
        w_filt    = filt_q[int'(t_q) * DATA_WIDTH +: DATA_WIDTH];
        row_out_d = '0;
        for (int c = 0; c < NC; c++) begin
            w_prod[c] = $signed(w_taps[c*DATA_WIDTH +: DATA_WIDTH]) * w_filt;
            acc_d[c]  = acc_q[c] + ACC_WIDTH'(w_prod[c]);
            w_sat[c]  = saturate(SAT_W'(acc_d[c]), FRAC_BITS, DATA_WIDTH);
`ifdef CONV_LINE_STREAM_RELU_EN
            if (w_sat[c][SAT_W-1]) begin
                w_sat[c] = '0;
            end
`else
            // Signed saturated value passes through unchanged.
`endif
            row_out_d[c*DATA_WIDTH +: DATA_WIDTH] = w_sat[c][DATA_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_LOAD;
            row_cnt_q   <= '0;
            filt_q      <= '0;
            t_q         <= '0;
            kx_q        <= '0;
            ky_q        <= '0;
            ch_q        <= '0;
            row_out_q   <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            for (int c = 0; c < NC; c++) begin
                acc_q[c] <= '0;
            end
        end else begin
            case (state_q)
                ST_LOAD: begin
                    // A filter captured alongside an accept feeds the MAC
                    // pass that this very accept starts.
                    if (bus.filter_load) begin
                        filt_q <= bus.filter_in;
                    end
                    if (bus.in_valid) begin
                        row_cnt_q <= row_cnt_q + RW'(1);
                        if (row_cnt_q + RW'(1) >= RW'(F)) begin
                            state_q <= ST_MAC;
                            t_q     <= '0;
                            kx_q    <= '0;
                            ky_q    <= '0;
                            ch_q    <= '0;
                            for (int c = 0; c < NC; c++) begin
                                acc_q[c] <= '0;
                            end
                        end
                    end
                end
                ST_MAC: begin
                    for (int c = 0; c < NC; c++) begin
                        acc_q[c] <= acc_d[c];
                    end
                    if (t_q == TW'(TAPS - 1)) begin
                        state_q     <= ST_OUT;
                        row_out_q   <= row_out_d;
                        out_valid_q <= 1'b1;
                        // row_cnt already counts the triggering row, so the
                        // frame's last row leaves it at H.
                        out_last_q  <= (row_cnt_q == RW'(H));
                    end else begin
                        // Tap order t = (ch*F + ky)*F + kx: kx fastest.
                        t_q <= t_q + TW'(1);
                        if (kx_q == KW'(F - 1)) begin
                            kx_q <= '0;
                            if (ky_q == KW'(F - 1)) begin
                                ky_q <= '0;
                                ch_q <= ch_q + CW'(1);
                            end else begin
                                ky_q <= ky_q + KW'(1);
                            end
                        end else begin
                            kx_q <= kx_q + KW'(1);
                        end
                    end
                end
                ST_OUT: begin
                    if (bus.out_ready) begin
                        state_q     <= ST_LOAD;
                        out_valid_q <= 1'b0;
                        out_last_q  <= 1'b0;
                        // Buffer is not cleared between frames; restarting
                        // the count makes the next frame refill F rows.
                        if (out_last_q) begin
                            row_cnt_q <= '0;
                        end
                    end
                end
                default: begin
                    state_q <= ST_LOAD;
                end
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_conv_line_stream.sv
`default_nettype none
// ============================================================================
//  Module      : tb_conv_line_stream
//  Description : Self-checking bench for conv_line_stream (D=2, F=3, W=8,
//                H=5). Expected rows come from a direct convolution over the
//                rows accepted so far in the current frame.
//  Config      : honours CONV_LINE_STREAM_RELU_EN in the reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_conv_line_stream;
    localparam int DW   = 16;
    localparam int FB   = 8;
    localparam int D    = 2;
    localparam int H    = 5;
    localparam int W    = 8;
    localparam int F    = 3;
    localparam int TAPS = D * F * F;
    localparam int NC   = W - F + 1;

    typedef int row_t  [D][W];
    typedef int filt_t [D][F][F];

    logic clk = 1'b0;
    logic reset;

    conv_line_stream_if #(.DATA_WIDTH(DW), .D(D), .W(W), .F(F)) bus ();

    conv_line_stream #(
        .DATA_WIDTH (DW),
        .FRAC_BITS  (FB),
        .D          (D),
        .H          (H),
        .W          (W),
        .F          (F)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    row_t  cur_row;
    row_t  frame_rows [$];
    filt_t m_filt;
    filt_t new_filt;
    int    n_vec;
    int    n_err;
    int    frame_row;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [D*W*DW-1:0] pack_row(input row_t r);
        logic [D*W*DW-1:0] v;
        v = '0;
        for (int ch = 0; ch < D; ch++)
            for (int x = 0; x < W; x++)
                v[(ch*W + x)*DW +: DW] = DW'(r[ch][x]);
        return v;
    endfunction

    function automatic logic [D*F*F*DW-1:0] pack_filt(input filt_t f);
        logic [D*F*F*DW-1:0] v;
        v = '0;
        for (int ch = 0; ch < D; ch++)
            for (int ky = 0; ky < F; ky++)
                for (int kx = 0; kx < F; kx++)
                    v[((ch*F + ky)*F + kx)*DW +: DW] = DW'(f[ch][ky][kx]);
        return v;
    endfunction

    // Direct convolution over the last F rows of the frame, then fixed-point
    // rescale, clamp and optional rectification.
    function automatic logic [NC*DW-1:0] model_out();
        logic [NC*DW-1:0] v;
        longint s;
        int n;
        n = frame_rows.size();
        v = '0;
        for (int c = 0; c < NC; c++) begin
            s = 0;
            for (int ch = 0; ch < D; ch++)
                for (int ky = 0; ky < F; ky++)
                    for (int kx = 0; kx < F; kx++)
                        s += longint'(frame_rows[n - F + ky][ch][c + kx]) *
                             longint'(m_filt[ch][ky][kx]);
            s = s >>> FB;
            if (s > 32767)  s = 32767;
            if (s < -32768) s = -32768;
`ifdef CONV_LINE_STREAM_RELU_EN
            if (s < 0) s = 0;
`endif
            v[c*DW +: DW] = DW'(s);
        end
        return v;
    endfunction

    task automatic rand_filt();
        for (int ch = 0; ch < D; ch++)
            for (int ky = 0; ky < F; ky++)
                for (int kx = 0; kx < F; kx++)
                    new_filt[ch][ky][kx] = int'($urandom_range(0, 511)) - 256;
    endtask

    task automatic make_row(input int kind, input int r);
        for (int ch = 0; ch < D; ch++)
            for (int x = 0; x < W; x++)
                case (kind)
                    0:       cur_row[ch][x] = (ch == 0) ? ((r*8 + x) << FB)
                                              : int'($urandom_range(0, 65535)) - 32768;
                    1:       cur_row[ch][x] = 256;
                    2:       cur_row[ch][x] = 127 * 256;
                    3:       cur_row[ch][x] = int'($urandom_range(0, 2047)) - 1024;
                    default: cur_row[ch][x] = int'($urandom_range(0, 4095));
                endcase
    endtask

    // Offers one row, then checks either "no output" (filling) or the full
    // output transfer: latency, optional backpressure hold, data, out_last.
    task automatic push_row(input bit with_load, input bit load_in_mac, input int hold);
        int lat;
        logic [NC*DW-1:0] exp_row;
        bit last;
        bus.row_in   = pack_row(cur_row);
        bus.in_valid = 1'b1;
        if (with_load) begin
            bus.filter_in   = pack_filt(new_filt);
            bus.filter_load = 1'b1;
        end
        lat = 0;
        while (!bus.in_ready && lat < 200) begin
            @(posedge clk); #1; lat++;
        end
        check("in_ready_before_accept", 256'(bus.in_ready), 256'(1));
        @(posedge clk); #1;
        bus.in_valid    = 1'b0;
        bus.filter_load = 1'b0;
        if (with_load) m_filt = new_filt;
        frame_rows.push_back(cur_row);
        frame_row++;
        if (frame_row < F) begin
            check("no_out_while_filling", 256'(bus.out_valid), 256'(0));
            check("ready_while_filling", 256'(bus.in_ready), 256'(1));
            return;
        end
        exp_row = model_out();
        last    = (frame_row == H);
        lat     = 1;
        while (!bus.out_valid && lat < 200) begin
            if (load_in_mac && lat == 3) begin
                bus.filter_in   = ~pack_filt(m_filt);
                bus.filter_load = 1'b1;
            end else begin
                bus.filter_load = 1'b0;
            end
            @(posedge clk); #1; lat++;
        end
        bus.filter_load = 1'b0;
        check("latency", 256'(lat), 256'(TAPS + 1));
        for (int i = 0; i < hold; i++) begin
            check("hold_row_out", 256'(bus.row_out), 256'(exp_row));
            check("hold_out_valid", 256'(bus.out_valid), 256'(1));
            check("hold_in_ready", 256'(bus.in_ready), 256'(0));
            @(posedge clk); #1;
        end
        check("row_out", 256'(bus.row_out), 256'(exp_row));
        check("out_last", 256'(bus.out_last), 256'(last));
        check("in_ready_in_out", 256'(bus.in_ready), 256'(0));
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        check("single_transfer", 256'(bus.out_valid), 256'(0));
        check("ready_after_out", 256'(bus.in_ready), 256'(1));
        if (last) begin
            frame_row = 0;
            frame_rows.delete();
        end
    endtask

    task automatic run_frame(input int kind, input bit load_first, input int hold2,
                             input int mac_load_row, input int load_row);
        for (int r = 0; r < H; r++) begin
            make_row(kind, r);
            if (r == load_row) rand_filt();
            push_row((r == 0 && load_first) || (r == load_row), r == mac_load_row,
                     (r == 2) ? hold2 : int'($urandom_range(0, 2)));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        n_vec = 0;
        n_err = 0;
        frame_row = 0;
        bus.in_valid    = 1'b0;
        bus.row_in      = '0;
        bus.filter_load = 1'b0;
        bus.filter_in   = '0;
        bus.out_ready   = 1'b0;
        for (int ch = 0; ch < D; ch++)
            for (int ky = 0; ky < F; ky++)
                for (int kx = 0; kx < F; kx++)
                    m_filt[ch][ky][kx] = 0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_in_ready", 256'(bus.in_ready), 256'(1));
        check("reset_out_valid", 256'(bus.out_valid), 256'(0));
        check("reset_out_last", 256'(bus.out_last), 256'(0));
        check("reset_row_out", 256'(bus.row_out), 256'(0));
        reset = 1'b0;

        // Identity filter: centre tap of channel 0 only.
        new_filt = m_filt;
        new_filt[0][1][1] = 1 << FB;
        run_frame(0, 1'b1, 0, -1, -1);

        // Box sum, then the same with saturating pixels (second frame).
        for (int ch = 0; ch < D; ch++)
            for (int ky = 0; ky < F; ky++)
                for (int kx = 0; kx < F; kx++)
                    new_filt[ch][ky][kx] = 256;
        run_frame(1, 1'b1, 0, -1, -1);
        run_frame(2, 1'b0, 0, -1, -1);

        // Random data with a 20-cycle backpressure hold on the first output.
        rand_filt();
        run_frame(3, 1'b1, 20, -1, -1);

        // filter_load ignored in MAC (row 2), honoured with an accept (row 3).
        run_frame(3, 1'b0, 1, 2, 3);

        // Reset in the middle of a MAC pass.
        for (int r = 0; r < F - 1; r++) begin
            make_row(3, r);
            push_row(1'b0, 1'b0, 0);
        end
        make_row(3, F - 1);
        bus.row_in   = pack_row(cur_row);
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        frame_rows.delete();
        frame_row = 0;
        for (int ch = 0; ch < D; ch++)
            for (int ky = 0; ky < F; ky++)
                for (int kx = 0; kx < F; kx++)
                    m_filt[ch][ky][kx] = 0;
        seen = 0;
        for (int i = 0; i < TAPS + 5; i++) begin
            if (bus.out_valid) seen = 1;
            @(posedge clk); #1;
        end
        check("no_out_after_reset", 256'(seen), 256'(0));
        check("ready_after_reset", 256'(bus.in_ready), 256'(1));
        rand_filt();
        run_frame(3, 1'b1, 0, -1, -1);

        // Negative centre tap on positive pixels (rectified when enabled).
        for (int ch = 0; ch < D; ch++)
            for (int ky = 0; ky < F; ky++)
                for (int kx = 0; kx < F; kx++)
                    new_filt[ch][ky][kx] = 0;
        new_filt[0][1][1] = -256;
        run_frame(4, 1'b1, 0, -1, -1);

        // Back-to-back random frames.
        rand_filt();
        run_frame(3, 1'b1, 2, -1, -1);
        run_frame(4, 1'b0, 0, -1, -1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire
